// File: rtl/sipo_8_bit_pkg.sv
// Shared definitions for the serial-in/parallel-out receiver and the
// downstream register stage: FSM state encodings and the default word width.
package sipo_8_bit_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } sipo_state_t;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/sipo_8_bit.sv
// Serial-in/parallel-out receiver: assembles WIDTH bits strobed by en after an
// explicit start, then presents the word on q with a one-cycle valid pulse.
module sipo_8_bit
  import sipo_8_bit_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic             en,
  input  logic             din,
  output logic [WIDTH-1:0] q,
  output logic             valid,
  output logic             busy
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  sipo_state_t      state;
  sipo_state_t      state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] sr_nxt;
  logic             shift_bit;
  logic             last_bit;

  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] cur,
                                                input logic             bit_in);
    if (LSB_FIRST)
      return {bit_in, cur[WIDTH-1:1]};
    else
      return {cur[WIDTH-2:0], bit_in};
  endfunction

  // start always wins over a strobe on the same edge, so the bit is dropped
  assign shift_bit = (state == SHIFT) && !start && en;
  assign last_bit  = shift_bit && (cnt == LAST_CNT);
  assign sr_nxt    = shift_in(sr, din);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (last_bit) state_nxt = DONE;
      DONE:    state_nxt = start ? SHIFT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr)
      cnt <= '0;
    else if (start || state != SHIFT || last_bit)
      cnt <= '0;
    else if (shift_bit)
      cnt <= cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr)
      sr <= '0;
    else if (start)
      sr <= '0;
    else if (shift_bit)
      sr <= sr_nxt;
  end

  // q only moves on a completed frame; restarts leave the previous word intact
  always_ff @(posedge clk or negedge clr) begin
    if (!clr)
      q <= '0;
    else if (last_bit)
      q <= sr_nxt;
  end

  assign valid = (state == DONE);
  assign busy  = (state == SHIFT);

endmodule
